// File: rtl/eco32f_pkg.sv
// eco32f shared package: register-file geometry and write-port arbiter defaults.
// Holds RF_ADDR_W/RF_DATA_W/RF_NREGS, RF_ZERO, STARVE_LIMIT_DEF and the grant encoding.
package eco32f_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_NREGS  = 32;

    localparam logic [RF_ADDR_W-1:0] RF_ZERO = 5'd0;

    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_HOLD,
        GNT_DIV
    } wport_gnt_e;

endpackage

// File: rtl/eco32f_rf_scoreboard.sv
// eco32f_rf_scoreboard: busy bit per register for pending divider writes.
// Ports: clk, rst (sync, high), set_en/set_addr, clr_en/clr_addr, flush, busy[RF_NREGS].
module eco32f_rf_scoreboard
    import eco32f_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [RF_ADDR_W-1:0] set_addr,
    input  logic                 clr_en,
    input  logic [RF_ADDR_W-1:0] clr_addr,
    input  logic                 flush,
    output logic [RF_NREGS-1:0]  busy
);

    logic [RF_NREGS-1:0] busy_d;

    // Set is applied after clear so a same-bit collision leaves it busy.
    always_comb begin
        busy_d = busy;
        if (clr_en)
            busy_d[clr_addr] = 1'b0;
        if (set_en)
            busy_d[set_addr] = 1'b1;
        if (flush)
            busy_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_d;
    end

    // Re-issuing to a busy register is only legal when that register
    // is being released in the same cycle.
    a_no_double_issue: assert property (@(posedge clk) disable iff (rst)
        (set_en && !flush) |->
            (!busy[set_addr] || (clr_en && clr_addr == set_addr)));

endmodule

// File: rtl/eco32f_rf_wport_arbiter.sv
// eco32f_rf_wport_arbiter: shares the RF write port between writeback and divider.
// Ports: wb_rf_r_* (pipeline write), div_* (divider), pipe_stall, rf_we/waddr/wdata, rf_busy.
// Optional macro ECO32F_RF_WPORT_BYPASS_EN: same-cycle divider write when the port is free.
module eco32f_rf_wport_arbiter
    import eco32f_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_rf_r_we,
    input  logic [RF_ADDR_W-1:0] wb_rf_r_addr,
    input  logic [RF_DATA_W-1:0] wb_rf_r,
    input  logic                 div_issue,
    input  logic [RF_ADDR_W-1:0] div_issue_addr,
    input  logic                 div_valid,
    output logic                 div_ready,
    input  logic [RF_ADDR_W-1:0] div_addr,
    input  logic [RF_DATA_W-1:0] div_result,
    input  logic                 div_flush,
    output logic                 pipe_stall,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [RF_DATA_W-1:0] rf_wdata,
    output logic [RF_NREGS-1:0]  rf_busy
);

    localparam logic [CNT_W-1:0] FORCE_AT = CNT_W'(STARVE_LIMIT - 1);

    logic                 hold_valid;
    logic [RF_ADDR_W-1:0] hold_addr;
    logic [RF_DATA_W-1:0] hold_data;
    logic [CNT_W-1:0]     starve_cnt;
    logic                 force_q;

    wport_gnt_e           gnt;
    logic                 pipe_req;
    logic                 hold_wr;
    logic                 div_wr;
    logic                 accept;

    assign pipe_req  = wb_rf_r_we && (wb_rf_r_addr != RF_ZERO);
    assign div_ready = !hold_valid && !div_flush;
    assign pipe_stall = force_q && hold_valid;

    always_comb begin
        gnt = GNT_NONE;
        if (force_q && hold_valid)
            gnt = GNT_HOLD;
        else if (pipe_req)
            gnt = GNT_PIPE;
        else if (hold_valid)
            gnt = GNT_HOLD;
`ifdef ECO32F_RF_WPORT_BYPASS_EN
        else if (div_valid && div_ready)
            gnt = GNT_DIV;
`endif
    end

    assign hold_wr = (gnt == GNT_HOLD);
    assign div_wr  = (gnt == GNT_DIV);
    // A bypassed result is written directly and never enters the hold.
    assign accept  = div_valid && div_ready && !div_wr;

    // r0 results still consume their grant so the hold drains, but no
    // write is emitted.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = RF_ZERO;
        rf_wdata = '0;
        unique case (gnt)
            GNT_PIPE: begin
                rf_we    = 1'b1;
                rf_waddr = wb_rf_r_addr;
                rf_wdata = wb_rf_r;
            end
            GNT_HOLD: begin
                if (hold_addr != RF_ZERO) begin
                    rf_we    = 1'b1;
                    rf_waddr = hold_addr;
                    rf_wdata = hold_data;
                end
            end
            GNT_DIV: begin
                if (div_addr != RF_ZERO) begin
                    rf_we    = 1'b1;
                    rf_waddr = div_addr;
                    rf_wdata = div_result;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_addr  <= RF_ZERO;
            hold_data  <= '0;
            starve_cnt <= '0;
            force_q    <= 1'b0;
        end else if (div_flush) begin
            hold_valid <= 1'b0;
            starve_cnt <= '0;
            force_q    <= 1'b0;
        end else begin
            if (hold_wr) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_valid <= 1'b1;
                hold_addr  <= div_addr;
                hold_data  <= div_result;
            end
            // A valid hold that is not granted has lost to the pipeline.
            if (hold_wr || !hold_valid) begin
                starve_cnt <= '0;
                force_q    <= 1'b0;
            end else begin
                starve_cnt <= starve_cnt + 1'b1;
                force_q    <= (starve_cnt == FORCE_AT);
            end
        end
    end

    eco32f_rf_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (div_issue && (div_issue_addr != RF_ZERO)),
        .set_addr (div_issue_addr),
        .clr_en   (hold_wr || div_wr),
        .clr_addr (div_wr ? div_addr : hold_addr),
        .flush    (div_flush),
        .busy     (rf_busy)
    );

    a_no_busy_pipe_write: assert property (@(posedge clk) disable iff (rst)
        pipe_req |-> !rf_busy[wb_rf_r_addr]);

endmodule

// File: tb/tb_eco32f_rf_wport_arbiter.sv
// Directed table-driven bench for eco32f_rf_wport_arbiter.
// Vectors apply on the falling edge; outputs are checked 1ns later.
module tb_eco32f_rf_wport_arbiter;

`ifdef ECO32F_RF_WPORT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_rf_r_we;
    logic [4:0]  wb_rf_r_addr;
    logic [31:0] wb_rf_r;
    logic        div_issue;
    logic [4:0]  div_issue_addr;
    logic        div_valid;
    logic        div_ready;
    logic [4:0]  div_addr;
    logic [31:0] div_result;
    logic        div_flush;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    eco32f_rf_wport_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_rf_r_we     (wb_rf_r_we),
        .wb_rf_r_addr   (wb_rf_r_addr),
        .wb_rf_r        (wb_rf_r),
        .div_issue      (div_issue),
        .div_issue_addr (div_issue_addr),
        .div_valid      (div_valid),
        .div_ready      (div_ready),
        .div_addr       (div_addr),
        .div_result     (div_result),
        .div_flush      (div_flush),
        .pipe_stall     (pipe_stall),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .rf_busy        (rf_busy)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ia;
        logic        dv;
        logic [4:0]  da;
        logic [31:0] dr;
        logic        fl;
        logic        e_rdy;
        logic        e_stl;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic we, logic [4:0] wa, logic [31:0] wd,
        logic iss, logic [4:0] ia,
        logic dv, logic [4:0] da, logic [31:0] dr, logic fl,
        logic e_rdy, logic e_stl, logic e_we,
        logic [4:0] e_wa, logic [31:0] e_wd, logic [31:0] e_busy);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.iss = iss; v.ia = ia;
        v.dv = dv; v.da = da; v.dr = dr; v.fl = fl;
        v.e_rdy = e_rdy; v.e_stl = e_stl; v.e_we = e_we;
        v.e_wa = e_wa; v.e_wd = e_wd; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(logic we, logic [4:0] wa, logic [31:0] wd,
                         logic iss, logic [4:0] ia, logic dv,
                         logic [4:0] da, logic [31:0] dr, logic fl);
        wb_rf_r_we = we; wb_rf_r_addr = wa; wb_rf_r = wd;
        div_issue = iss; div_issue_addr = ia;
        div_valid = dv; div_addr = da; div_result = dr;
        div_flush = fl;
    endtask

    task automatic chk_all(string tag, logic rdy, logic stl, logic we,
                           logic [4:0] wa, logic [31:0] wd, logic [31:0] busy);
        chk({tag, ".div_ready"},  32'(div_ready),  32'(rdy));
        chk({tag, ".pipe_stall"}, 32'(pipe_stall), 32'(stl));
        chk({tag, ".rf_we"},      32'(rf_we),      32'(we));
        chk({tag, ".rf_waddr"},   32'(rf_waddr),   32'(wa));
        chk({tag, ".rf_wdata"},   rf_wdata,        wd);
        chk({tag, ".rf_busy"},    rf_busy,         busy);
    endtask

    localparam logic [31:0] B4  = 32'd1 << 4;
    localparam logic [31:0] B5  = 32'd1 << 5;
    localparam logic [31:0] B7  = 32'd1 << 7;
    localparam logic [31:0] B9  = 32'd1 << 9;
    localparam logic [31:0] B12 = 32'd1 << 12;
    localparam logic [31:0] B13 = 32'd1 << 13;

    initial begin
        // idle after reset
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 1,0,0,0,0,0));
        // issue r5, result r5=0x2A with port free
        tbl.push_back(mk(0,0,0, 1,5, 0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,0, 1,5,32'h2A,0,
                         1,0,BYP,BYP ? 5'd5 : 5'd0,BYP ? 32'h2A : 32'h0,B5));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0,
                         BYP,0,!BYP,BYP ? 5'd0 : 5'd5,BYP ? 32'h0 : 32'h2A,
                         BYP ? 32'h0 : B5));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 1,0,0,0,0,0));
        // starvation: hold r7=0x11 against continuous pipeline writes
        tbl.push_back(mk(0,0,0, 1,7, 0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,1,32'h101, 0,0, 1,7,32'h11,0, 1,0,1,1,32'h101,B7));
        tbl.push_back(mk(1,2,32'h102, 0,0, 0,0,0,0, 0,0,1,2,32'h102,B7));
        tbl.push_back(mk(1,3,32'h103, 0,0, 0,0,0,0, 0,0,1,3,32'h103,B7));
        tbl.push_back(mk(1,4,32'h104, 0,0, 0,0,0,0, 0,0,1,4,32'h104,B7));
        tbl.push_back(mk(1,5,32'h105, 0,0, 0,0,0,0, 0,0,1,5,32'h105,B7));
        tbl.push_back(mk(1,6,32'h106, 0,0, 0,0,0,0, 0,1,1,7,32'h11,B7));
        tbl.push_back(mk(1,6,32'h106, 0,0, 0,0,0,0, 1,0,1,6,32'h106,0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 1,0,0,0,0,0));
        // pipe r3 and hold r4 in the same cycle
        tbl.push_back(mk(0,0,0, 1,4, 0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,2,32'h22, 0,0, 1,4,32'h44,0, 1,0,1,2,32'h22,B4));
        tbl.push_back(mk(1,3,32'h33, 0,0, 0,0,0,0, 0,0,1,3,32'h33,B4));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 0,0,1,4,32'h44,B4));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 1,0,0,0,0,0));
        // flush with hold valid and a concurrent pipeline write
        tbl.push_back(mk(0,0,0, 1,12, 0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,1,32'h1, 0,0, 1,12,32'hCC,0, 1,0,1,1,32'h1,B12));
        tbl.push_back(mk(1,2,32'h2, 0,0, 1,12,32'hDD,1, 0,0,1,2,32'h2,B12));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 1,0,0,0,0,0));
        // flush drops a div_valid with the hold empty
        tbl.push_back(mk(0,0,0, 1,13, 0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,0, 1,13,32'hEE,1, 0,0,0,0,0,B13));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 1,0,0,0,0,0));
        // issue r9 while the hold writes r9
        tbl.push_back(mk(0,0,0, 1,9, 0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,1,32'h1, 0,0, 1,9,32'h99,0, 1,0,1,1,32'h1,B9));
        tbl.push_back(mk(0,0,0, 1,9, 0,0,0,0, 0,0,1,9,32'h99,B9));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 1,0,0,0,0,B9));
        // r0 result is drained without a write
        tbl.push_back(mk(1,1,32'h1, 0,0, 1,0,32'h55,0, 1,0,1,1,32'h1,B9));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0,B9));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 1,0,0,0,0,B9));
        // pipeline write to r0 is suppressed
        tbl.push_back(mk(1,0,32'h77, 0,0, 0,0,0,0, 1,0,0,0,0,B9));

        rst = 1'b1;
        drive(0,0,0, 0,0, 0,0,0,0);
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = 1'b0;
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].iss, tbl[i].ia,
                  tbl[i].dv, tbl[i].da, tbl[i].dr, tbl[i].fl);
            #1;
            chk_all($sformatf("v%0d", i), tbl[i].e_rdy, tbl[i].e_stl,
                    tbl[i].e_we, tbl[i].e_wa, tbl[i].e_wd, tbl[i].e_busy);
        end

        // reset asserted in the forced-drain cycle
        @(negedge clk);
        drive(0,0,0, 1,10, 0,0,0,0);
        @(negedge clk);
        drive(1,1,32'h1, 0,0, 1,10,32'hAA,0);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            drive(1,5'(k),32'(k), 0,0, 0,0,0,0);
            #1;
            chk_all($sformatf("rf_starve%0d", k), 0, 0, 1, 5'(k), 32'(k),
                    B9 | (32'd1 << 10));
        end
        @(negedge clk);
        drive(1,6,32'h6, 0,0, 0,0,0,0);
        rst = 1'b1;
        #1;
        chk_all("rf_force", 0, 1, 1, 10, 32'hAA, B9 | (32'd1 << 10));
        @(negedge clk);
        rst = 1'b0;
        drive(0,0,0, 0,0, 0,0,0,0);
        #1;
        chk_all("post_rst", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1,6,32'h6, 0,0, 0,0,0,0);
        #1;
        chk_all("post_rst_pipe", 1, 0, 1, 6, 32'h6, 0);
        @(negedge clk);
        drive(0,0,0, 0,0, 0,0,0,0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eco32f_rf_wport_arbiter.md
Name: eco32f_rf_wport_arbiter

Overview:
Shares the single register-file write port between the in-order writeback stage and the multi-cycle divider.
- Pipeline writes normally win.
- The divider result waits in a one-entry hold buffer.
- A starvation counter forces a one-cycle pipeline stall so the buffered result drains.
- A 32-entry scoreboard of pending divider destinations is exported for decode hazard detection.

Parameters:
STARVE_LIMIT, 4, consecutive cycles a valid hold entry may lose the port before pipe_stall is forced (1..15).
CNT_W, 4, starvation counter width; must hold STARVE_LIMIT.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active high
wb_rf_r_we  in  1  writeback stage write request
wb_rf_r_addr  in  5  writeback destination
wb_rf_r  in  32  writeback data
div_issue  in  1  divide issued to divider this cycle
div_issue_addr  in  5  destination of issued divide
div_valid  in  1  divider result available
div_ready  out  1  arbiter accepts divider result
div_addr  in  5  divider result destination
div_result  in  32  divider result data
div_flush  in  1  exception flush; discard divider state
pipe_stall  out  1  stall request to pipeline (holds writeback regs)
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  32  register-file write data
rf_busy  out  32  bit n set: divider write to rn pending

Behaviour:
- Reset: hold_valid=0, starve_cnt=0, force=0, rf_busy=0.
  - Resulting outputs: div_ready=1, pipe_stall=0, rf_we=0, rf_waddr=0, rf_wdata=0.
- Reset wins over every other input in the same cycle, including mid-hold, mid-force and flush.
- div_ready = !hold_valid && !div_flush.
  - Accept on the edge where div_valid && div_ready: latch div_addr/div_result, set hold_valid.
- Write-port grant, evaluated combinationally each cycle:
  - force=1 and hold_valid: grant hold. pipe_stall=1. The pipeline write is not performed; it remains presented next cycle because writeback is stalled.
  - else wb_rf_r_we && wb_rf_r_addr!=0: grant pipeline.
  - else hold_valid: grant hold.
  - else rf_we=0, rf_waddr=0, rf_wdata=0.
- Hold granted: rf_we=1, hold_valid clears at the edge, and the busy bit of the hold address clears.
- Writes to r0 are never emitted; a hold entry for r0 is discarded on the next port-free cycle.
- Starvation counter:
  - Increments each cycle hold_valid && pipeline granted.
  - Clears when hold is granted or hold_valid=0.
  - At STARVE_LIMIT, force is set at the edge and lasts exactly one cycle (until the hold write).
- Scoreboard:
  - div_issue sets rf_busy[div_issue_addr], except r0.
  - Same-cycle set and clear of the same bit: set wins.
  - div_issue to an already busy register is illegal (decode guarantees it does not happen); simulation assertion.
- div_flush:
  - Clears hold_valid, starve_cnt, force and all rf_busy; any div_valid that cycle is dropped.
  - A same-cycle pipeline write is still granted.
- A pipeline write to a busy register is illegal (decode stalls on rf_busy); simulation assertion.
- Latency: divider result to rf_we is ≥1 cycle (buffered), ≤ STARVE_LIMIT+1 cycles after acceptance.

Optional Feature:
ECO32F_RF_WPORT_BYPASS_EN
- Defined: when hold is empty, there is no pipeline write and div_valid is high, the divider result is written in the same cycle.
  - rf_we=1 with div_addr/div_result, combinational path.
  - The result is not latched; its busy bit clears at the edge.
- Undefined: every divider result passes through the hold buffer (minimum 1-cycle latency). No combinational div_* to rf_* path.

Decomposition:
- Shared package eco32f_pkg holds:
  - RF_ADDR_W=5, RF_DATA_W=32, RF_NREGS=32.
  - RF_ZERO=5'd0.
  - Default STARVE_LIMIT constant.
- Sub-module eco32f_rf_scoreboard: busy vector with set/clear/flush ports, set-wins priority.
- Arbitration, hold buffer and counter stay in the top module.

Test Plan:
- Reset then idle:
  - Expect rf_we=0, div_ready=1, pipe_stall=0, rf_busy=0.
- div_issue r5, then div_valid r5=0x0000002A with no pipeline writes:
  - Bypass off: rf_we in the next cycle with addr 5, data 0x2A, and rf_busy[5] clears.
  - Bypass on: same-cycle write.
- Hold r7=0x11 with pipeline writing r1..r9 continuously, STARVE_LIMIT=4:
  - Pipeline wins 4 cycles.
  - Cycle 5: pipe_stall=1 and rf_waddr=7; the pipeline write resumes next cycle.
- Pipeline write r3 and hold r4 in the same cycle:
  - r3 written first, r4 written in the following free cycle; div_ready=0 until r4 is written.
- div_flush while hold_valid and rf_busy[12]:
  - Next cycle hold empty, rf_busy=0; a div_valid presented during the flush is never written.
- div_issue r9 in the same cycle the hold writes r9:
  - rf_busy[9] stays 1.
- rst asserted while force=1:
  - Next cycle pipe_stall=0 and all state is cleared.
